// File: rtl/rom_rd_arbiter.sv
// Two-port read arbiter in front of a synchronous single-port ROM.
// Grants one read per cycle and returns each word on the issuing port after RD_LAT edges.
module rom_rd_arbiter #(
    parameter int unsigned ADDR_W    = 8,
    parameter int unsigned DATA_W    = 8,
    parameter int unsigned RD_LAT    = 2,
    parameter int unsigned FIXED_PRI = 0
) (
    input  logic              sys_clk,
    input  logic              sys_rst_n,
    input  logic              req0,
    input  logic [ADDR_W-1:0] addr0,
    output logic              gnt0,
    output logic              vld0,
    input  logic              req1,
    input  logic [ADDR_W-1:0] addr1,
    output logic              gnt1,
    output logic              vld1,
    output logic [DATA_W-1:0] rdata,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [DATA_W-1:0] rom_q
);

    localparam int unsigned TAG_LAST  = RD_LAT - 1;
    localparam bit          FIXED_WIN = (FIXED_PRI != 0);

    logic              last_gnt_q, last_gnt_d;
    logic [ADDR_W-1:0] rom_addr_q, rom_addr_d;
    logic [RD_LAT-1:0] tag_vld_q,  tag_vld_d;
    logic [RD_LAT-1:0] tag_port_q, tag_port_d;
    logic              vld0_q, vld0_d;
    logic              vld1_q, vld1_d;
    logic              xfer_c;

    // Grant: a lone requester wins; on contention port 0 wins under fixed priority,
    // otherwise the port that did not win last time. Nothing is granted in reset.
    always_comb begin : grant_comb
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (sys_rst_n) begin
            if (req0 && req1) begin
                if (FIXED_WIN || last_gnt_q) begin
                    gnt0 = 1'b1;
                end else begin
                    gnt1 = 1'b1;
                end
            end else begin
                gnt0 = req0;
                gnt1 = req1;
            end
        end
    end

    assign xfer_c = gnt0 | gnt1;

    // Issue tags {valid, port} march alongside the ROM latency.
    generate
        if (RD_LAT == 1) begin : g_tag_lat1
            assign tag_vld_d  = xfer_c;
            assign tag_port_d = gnt1;
        end else begin : g_tag_latn
            assign tag_vld_d  = {tag_vld_q[RD_LAT-2:0],  xfer_c};
            assign tag_port_d = {tag_port_q[RD_LAT-2:0], gnt1};
        end
    endgenerate

    always_comb begin : next_comb
        rom_addr_d = rom_addr_q;
        last_gnt_d = last_gnt_q;
        if (gnt0) begin
            rom_addr_d = addr0;
            last_gnt_d = 1'b0;
        end else if (gnt1) begin
            rom_addr_d = addr1;
            last_gnt_d = 1'b1;
        end
        vld0_d = tag_vld_q[TAG_LAST] & ~tag_port_q[TAG_LAST];
        vld1_d = tag_vld_q[TAG_LAST] &  tag_port_q[TAG_LAST];
    end

    // last_gnt resets to port 1 so port 0 takes the first contest.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin : state_ff
        if (!sys_rst_n) begin
            rom_addr_q <= '0;
            last_gnt_q <= 1'b1;
            tag_vld_q  <= '0;
            tag_port_q <= '0;
            vld0_q     <= 1'b0;
            vld1_q     <= 1'b0;
        end else begin
            rom_addr_q <= rom_addr_d;
            last_gnt_q <= last_gnt_d;
            tag_vld_q  <= tag_vld_d;
            tag_port_q <= tag_port_d;
            vld0_q     <= vld0_d;
            vld1_q     <= vld1_d;
        end
    end

    assign rom_addr = rom_addr_q;
    assign vld0     = vld0_q;
    assign vld1     = vld1_q;
    assign rdata    = rom_q;

    a_gnt_onehot : assert property (@(posedge sys_clk) !(gnt0 && gnt1));
    a_vld_onehot : assert property (@(posedge sys_clk) disable iff (!sys_rst_n) !(vld0 && vld1));

endmodule

// File: doc/rom_rd_arbiter.md
Name: rom_rd_arbiter

Overview:
- Shares one synchronous single-port ROM (rom_8x256 class: registered address, registered q) between two independent read requesters, e.g. a display scanner and a key-driven browser.
- Arbitrates each cycle (round-robin or fixed priority), drives the ROM address, and tracks every issued read through the ROM latency.
- Returns ROM data with a one-cycle valid pulse on the port that issued the read.
- Sits between the requester logic and the ROM instance.

Parameters:
- ADDR_W, 8, ROM address width.
- DATA_W, 8, ROM data width.
- RD_LAT, 2, clock edges from rom_addr changing to rom_q holding that word; legal range 1..4.
- FIXED_PRI, 0, 0 = round-robin; 1 = port 0 always wins.

Ports:
- sys_clk  in  1  system clock, rising edge.
- sys_rst_n  in  1  asynchronous active-low reset.
- req0  in  1  port 0 read request (valid).
- addr0  in  ADDR_W  port 0 read address; must be stable while req0 is high.
- gnt0  out  1  port 0 accept (ready), combinational.
- vld0  out  1  port 0 read data valid, one-cycle pulse.
- req1  in  1  port 1 read request.
- addr1  in  ADDR_W  port 1 read address.
- gnt1  out  1  port 1 accept, combinational.
- vld1  out  1  port 1 read data valid.
- rdata  out  DATA_W  shared return data; equals rom_q.
- rom_addr  out  ADDR_W  registered ROM address.
- rom_q  in  DATA_W  ROM output.

Behaviour:
- Reset, asynchronous: rom_addr=0, tag pipeline cleared, vld0=vld1=0, last_gnt=1 so port 0 wins the first contest.
- Outputs while in reset: gnt0=gnt1=0.
- Handshake: a read transfers at a rising edge where reqX=1 and gntX=1. A requester may hold reqX high for back-to-back reads and may change addrX only after a transfer.
- Grant logic, combinational from req0, req1 and last_gnt:
  - Only one req high: that port is granted.
  - Both high, FIXED_PRI=1: port 0 granted.
  - Both high, FIXED_PRI=0: the port other than last_gnt is granted.
  - gnt0 and gnt1 are never both 1. No req means no gnt.
- On a transfer edge:
  - rom_addr <= addr of the granted port.
  - last_gnt <= granted port.
  - An issue tag {valid, port} enters an RD_LAT-deep shift register.
- With no transfer: rom_addr holds its value; a tag with valid=0 enters the pipe.
- Return path:
  - vldX = tag output valid AND tag port == X.
  - rdata = rom_q, passed through combinationally.
  - For a read accepted at edge E, vldX is high for exactly the one cycle after edge E+RD_LAT, and rdata then holds ROM[addr].
- Throughput: one read per cycle total. Reads return in issue order. vld0 and vld1 are never both high.
- Round-robin fairness: with both requests held continuously, grants alternate 0,1,0,1...; neither port waits more than 1 cycle.
- No backpressure on the return path: the requester must capture rdata in the vld cycle.
- Reset mid-operation: all in-flight tags are discarded and no vld pulses occur after reset release for reads issued before reset.
- Widths: no arithmetic. The tag pipe is RD_LAT x 2 bits.

Test Plan:
- Single read: RD_LAT=2, ROM[i]=i+8'h10; req0=1, addr0=8'h05 for one transfer -> gnt0 high that cycle; rom_addr=8'h05 next cycle; vld0=1 with rdata=8'h15 exactly 2 cycles after gnt0; vld1 stays 0.
- Contention, round-robin: after reset, req0=req1=1 held with addr0=8'h00, addr1=8'h80 for 6 cycles -> grants 0,1,0,1,0,1; return sequence vld0/8'h10, vld1/8'h90, alternating, no bubbles.
- Fixed priority: FIXED_PRI=1, both requests held for 4 cycles -> gnt0=1 every cycle, gnt1=0, vld1 never asserted.
- Back-to-back streaming: req1 held, addr1 stepping 8'hFE, 8'hFF, 8'h00 after each grant -> rdata 8'h0E, 8'h0F, 8'h10 on consecutive vld1 cycles (wrap-around address).
- Reset mid-flight: issue two reads, assert sys_rst_n=0 one cycle later for 1 cycle -> rom_addr=0 immediately; no vld pulse afterwards; the next contest is won by port 0.
- Latency sweep: RD_LAT=1 and RD_LAT=4, single read of 8'h3C -> vld asserted 1 and 4 cycles respectively after gnt, with rdata=8'h4C.
